// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the Thumb fetch stage.
// Contents:
//   WORD               - instruction address width
//   fetch_state_t      - fetch FSM states
//   stall_pipeline_sig - pipeline-wide stall encoding
//   PC_INCREMENT       - sequential fetch stride (Thumb halfword)
//   PC_RESET_ADDR      - first fetch address after reset
//   align_halfword()   - forces bit 0 of an address to zero
package fetch_sequencer_pkg;

  localparam int unsigned WORD = 32;

  localparam logic [WORD-1:0] PC_INCREMENT  = WORD'(2);
  localparam logic [WORD-1:0] PC_RESET_ADDR = WORD'(0);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  typedef enum logic {
    NO_STALL       = 1'b0,
    STALL_PIPELINE = 1'b1
  } stall_pipeline_sig;

  // Thumb targets are halfword aligned; bit 0 carries no address information.
  function automatic logic [WORD-1:0] align_halfword(input logic [WORD-1:0] addr);
    return {addr[WORD-1:1], 1'b0};
  endfunction

endpackage : fetch_sequencer_pkg

// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer and its neighbours (hazard unit,
// branch resolver, data-memory stall source, instruction memory).
// Signals:
//   mem_stall_i      - data memory busy, freeze the whole pipeline
//   load_use_i       - one-cycle load-use bubble request
//   branch_taken_i   - execute stage resolved a taken branch
//   branch_target_i  - branch destination (bit 0 ignored)
//   pc_o             - instruction memory fetch address
//   stall_pipeline_o - holds IF/ID and ID/EX
//   flush_front_o    - clears IF/ID and ID/EX on the next edge
//   fetch_valid_o    - imem output this cycle is on the correct path
//   stall_count_o    - saturating stalled-cycle count
//   redirect_count_o - saturating applied-branch count
// Modports: master = fetch sequencer, slave = surrounding pipeline.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic              mem_stall_i;
  logic              load_use_i;
  logic              branch_taken_i;
  logic [WORD-1:0]   branch_target_i;

  logic [WORD-1:0]   pc_o;
  stall_pipeline_sig stall_pipeline_o;
  logic              flush_front_o;
  logic              fetch_valid_o;
  logic [CNT_W-1:0]  stall_count_o;
  logic [CNT_W-1:0]  redirect_count_o;

  modport master (
    input  mem_stall_i,
    input  load_use_i,
    input  branch_taken_i,
    input  branch_target_i,
    output pc_o,
    output stall_pipeline_o,
    output flush_front_o,
    output fetch_valid_o,
    output stall_count_o,
    output redirect_count_o
  );

  modport slave (
    output mem_stall_i,
    output load_use_i,
    output branch_taken_i,
    output branch_target_i,
    input  pc_o,
    input  stall_pipeline_o,
    input  flush_front_o,
    input  fetch_valid_o,
    input  stall_count_o,
    input  redirect_count_o
  );

endinterface : fetch_sequencer_if

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter used for the fetch performance statistics.
// Ports:
//   clk_i     - clock
//   reset_n_i - asynchronous active-low reset, clears the count
//   inc_i     - add one this cycle
//   count_o   - current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic at_max_c;

  assign at_max_c = &count_o;

  // Count register; increments are dropped once the counter is full.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_o <= '0;
    end else if (inc_i && !at_max_c) begin
      count_o <= count_o + CNT_W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer for the pipelined Thumb core.
// Owns the program counter, picks the next fetch address (sequential +2,
// hold, or branch redirect) and produces the stall, flush and fetch-valid
// controls for the front end.
// Ports:
//   clk_i     - clock, all state changes on the rising edge
//   reset_n_i - asynchronous active-low reset
//   bus       - fetch_sequencer_if.master (hazard, branch, imem, counters)
// stall_pipeline_o and flush_front_o are combinational from the inputs and
// current state; pc_o, fetch_valid_o and the counters come from registers.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  fetch_sequencer_if.master  bus
);

  fetch_state_t    state_q;
  fetch_state_t    state_d;
  logic [WORD-1:0] pc_q;
  logic [WORD-1:0] pc_d;

  logic            stall_c;
  logic            flush_c;

  // State and PC registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= BOOT;
      pc_q    <= PC_RESET_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state, next-PC and control decision. Memory stall dominates,
  // then a taken branch (which also drops a coincident load-use bubble,
  // since the dependent instruction is flushed), then load-use.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stall_c = 1'b0;
    flush_c = 1'b0;

    if (bus.mem_stall_i) begin
      // Full freeze: the resolver re-presents any branch afterwards.
      stall_c = 1'b1;
    end else if (bus.branch_taken_i) begin
      pc_d    = align_halfword(bus.branch_target_i);
      flush_c = 1'b1;
      state_d = REDIRECT;
    end else if (bus.load_use_i) begin
      stall_c = 1'b1;
    end else begin
      pc_d = pc_q + PC_INCREMENT;
      unique case (state_q)
        BOOT:     state_d = RUN;
        RUN:      state_d = RUN;
        REDIRECT: state_d = RUN;
        default:  state_d = BOOT;
      endcase
    end
  end

  // Controls read as inactive while reset is held, whatever the inputs do.
  assign bus.stall_pipeline_o = (reset_n_i && stall_c) ? STALL_PIPELINE : NO_STALL;
  assign bus.flush_front_o    = reset_n_i && flush_c;
  assign bus.pc_o             = pc_q;

  // Imem data is correct-path only once a sequential fetch has been issued
  // from a correct-path address; held imem output stays valid over stalls.
  assign bus.fetch_valid_o    = (state_q == RUN);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (stall_c),
    .count_o   (bus.stall_count_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (flush_c),
    .count_o   (bus.redirect_count_o)
  );

endmodule : fetch_sequencer

// File: doc/fetch_sequencer.md
# fetch_sequencer

- Sequences the fetch stage of the pipelined Thumb core.
- Owns the program-counter register and selects the next fetch address: sequential +2, hold for stall, or branch redirect.
- Generates the pipeline-wide stall, front-end flush and fetch-valid controls.
- Sits between the hazard unit, the execute-stage branch resolver, the data-memory stall source and the instruction memory.

## Interface
- `WORD`, 32: address width, from `GENERAL_DEFS`.
- `CNT_W`, 16: width of the saturating performance counters.
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `mem_stall_i`  in  1  data memory busy; the whole pipeline freezes.
- `load_use_i`  in  1  hazard unit requests a 1-cycle load-use bubble.
- `branch_taken_i`  in  1  execute stage resolved a taken branch this cycle.
- `branch_target_i`  in  WORD  branch destination; bit 0 is ignored and forced to 0.
- `pc_o`  out  WORD  address presented to instruction memory. Imem has a registered read, so data for `pc_o` arrives one cycle later.
- `stall_pipeline_o`  out  stall_pipeline_sig  `STALL_PIPELINE` holds IF/ID and ID/EX; otherwise `NO_STALL`.
- `flush_front_o`  out  1  clears IF/ID and ID/EX on the next edge.
- `fetch_valid_o`  out  1  imem output this cycle belongs to the correct path.
- `stall_count_o`  out  CNT_W  cycles spent stalled, saturating.
- `redirect_count_o`  out  CNT_W  taken branches applied, saturating.

## Operation
States:
- **BOOT**
  - Entered on reset.
  - No valid imem data yet.
  - Always goes to RUN on the next edge.
  - `pc_o` advances 0→2.
- **RUN**
  - Normal fetch.
- **REDIRECT**
  - The first cycle after a branch.
  - Imem output is wrong-path data.
  - `fetch_valid_o` = 0.
  - Goes to RUN on the next edge, unless `mem_stall_i` is high, in which case it stays in REDIRECT.

Per-cycle priority (combinational decision, registered on the edge):
1. `mem_stall_i`=1:
   - `pc_o` holds; FSM state holds.
   - `stall_pipeline_o`=STALL.
   - `branch_taken_i` and `load_use_i` are ignored; the execute stage re-presents the branch after the freeze.
   - `stall_count_o` += 1.
2. `branch_taken_i`=1:
   - `pc_o` ← {`branch_target_i`[WORD-1:1], 1'b0}.
   - `flush_front_o`=1.
   - Next state REDIRECT.
   - `redirect_count_o` += 1.
   - A simultaneous `load_use_i` is dropped, because the dependent instruction is flushed.
3. `load_use_i`=1:
   - `pc_o` holds; `stall_pipeline_o`=STALL.
   - `stall_count_o` += 1.
   - State is unchanged.
4. Otherwise:
   - `pc_o` ← `pc_o` + 2, modulo 2^WORD; 0xFFFF_FFFE wraps to 0x0000_0000.

Other rules:
- `fetch_valid_o` = 1 only in RUN.
  - It is 0 in BOOT and REDIRECT.
  - It is unaffected by stalls. A held imem output remains valid.
- A branch arriving in REDIRECT (back-to-back) is applied normally:
  - New target, flush again.
  - Stay in REDIRECT.
- Counters saturate at all-ones and never wrap.

Reset values (asserted asynchronously, held while `reset_n_i`=0):
- `pc_o`=0, state BOOT.
- `stall_pipeline_o`=NO_STALL, `flush_front_o`=0, `fetch_valid_o`=0.
- Both counters 0.

A reset asserted mid-stall or mid-redirect discards all state immediately.

## Timing
- `stall_pipeline_o` and `flush_front_o` are combinational from inputs and current state, with no registered delay.
  - Consumers sample them on the same edge that updates `pc_o`.
- Redirect penalty: a branch resolved in cycle N gives `pc_o`=target in N+1, with `fetch_valid_o`=0.
  - The target instruction is valid in N+2, with `fetch_valid_o`=1.
- Load-use costs exactly 1 cycle per assertion cycle. Multi-cycle assertion holds for as long as it is asserted.
- After reset deassertion, the first edge moves BOOT→RUN with `pc_o`=2.
  - The instruction at address 0 is valid in that cycle.

## Structure
- Add to `GENERAL_DEFS`:
  - `fetch_state_t` enum {BOOT, RUN, REDIRECT}.
  - `PC_INCREMENT` = 2.
  - `PC_RESET_ADDR` = 0.
- `stall_pipeline_sig` is reused unchanged.
- Sub-module `sat_counter` (parameter CNT_W; ports inc_i, count_o; async active-low reset), instantiated twice for the counters.
- The next-PC mux and the FSM live in `fetch_sequencer`.

## Test plan
- Reset then release, with no hazards:
  - `pc_o`: 0, 2, 4, 6.
  - `fetch_valid_o`: 0, 1, 1, 1.
- `load_use_i` pulsed 1 cycle at `pc_o`=8:
  - `stall_pipeline_o`=STALL for one cycle.
  - `pc_o`: 8, 8, A.
  - `stall_count_o`=1.
- `branch_taken_i` with target 0x0000_0101 at `pc_o`=0x10:
  - `flush_front_o`=1.
  - Next `pc_o`=0x100 with `fetch_valid_o`=0, then 0x102 with `fetch_valid_o`=1.
  - `redirect_count_o`=1.
- `mem_stall_i` held 3 cycles together with `branch_taken_i`:
  - `pc_o` frozen for 3 cycles; no flush.
  - `stall_count_o`=3.
  - The branch is applied on the cycle `mem_stall_i` drops.
- `branch_taken_i` and `load_use_i` simultaneously:
  - Branch applied, no stall.
  - `stall_count_o` unchanged.
- Edge cases:
  - Starting from `pc_o`=0xFFFF_FFFE: `pc_o` wraps to 0.
  - Counters preloaded near saturation via a long stall hold at 0xFFFF and do not wrap.
  - `reset_n_i` asserted mid-REDIRECT forces all outputs to reset values without a clock edge.
